// File: rtl/addsub_rr_sched_pkg.sv
// addsub_sched_pkg: shared types and the round-robin pick function for the add/sub scheduler.
package addsub_sched_pkg;
  localparam int MAX_NREQ = 16;
  localparam int MAX_IDW = 4;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef struct packed {
    logic gt;
    logic [MAX_W-1:0] data;
    logic [MAX_IDW-1:0] id;
  } res_t;
  typedef struct packed {
    logic found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;
  // First valid requester at or after ptr, wrapping at n; ptr must be below n.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid, input int ptr, input int n);
    pick_t p;
    int j;
    p = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      j = ptr + i;
      if (j >= n) j -= n;
      if (i < n && !p.found && valid[MAX_IDW'(j)]) begin
        p.found = 1'b1;
        p.idx = MAX_IDW'(j);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/addsub_rr_sched_stage.sv
// addsub_stage: registered unsigned compare plus add (A>B) or subtract (A<=B), holds when not loaded.
module addsub_stage import addsub_sched_pkg::*; #(
  parameter int W = 8,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [IDW-1:0] id_i,
  output logic [W-1:0]   xout_o,
  output logic           gt_o,
  output logic [IDW-1:0] xid_o
);
  res_t res_q;
  logic gt;
  logic [W-1:0] x;
  always_comb begin
    gt = a_i > b_i;
    x = gt ? a_i + b_i : a_i - b_i;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) res_q <= '0;
    else if (load_i) res_q <= '{gt: gt, data: MAX_W'(x), id: MAX_IDW'(id_i)};
  end
  assign xout_o = W'(res_q.data);
  assign gt_o = res_q.gt;
  assign xid_o = IDW'(res_q.id);
endmodule

// File: rtl/addsub_rr_sched.sv
// addsub_rr_sched: round-robin arbiter feeding one registered add/sub stage, result returned with requester id.
module addsub_rr_sched import addsub_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*W-1:0]       req_a_i,
  input  logic [NREQ*W-1:0]       req_b_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [W-1:0]            res_data_o,
  output logic                    res_gt_o,
  output logic [$clog2(NREQ)-1:0] res_id_o
);
  localparam int IDW = $clog2(NREQ);
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, win;
  logic [W-1:0] a_q, b_q;
  pick_t pick;
  logic hs, grant;
  // Grant is gated by reset so no ready pulse escapes while reset is held.
  always_comb begin
    pick = rr_pick(MAX_NREQ'(req_valid_i), int'(ptr_q), NREQ);
    win = IDW'(pick.idx);
    hs = state_q == RESP && res_ready_i;
    grant = rst_n && pick.found && (state_q == IDLE || hs);
    state_d = state_q == EXEC ? RESP : (state_q == IDLE || hs) ? (grant ? EXEC : IDLE) : RESP;
    ptr_d = grant ? (win == IDW'(NREQ - 1) ? '0 : win + IDW'(1)) : ptr_q;
    req_ready_o = grant ? NREQ'(1) << win : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      if (grant) begin
        a_q <= W'(req_a_i >> (W * int'(win)));
        b_q <= W'(req_b_i >> (W * int'(win)));
        id_q <= win;
      end
    end
  end
  addsub_stage #(.W(W), .IDW(IDW)) u_stage (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(state_q == EXEC),
    .a_i(a_q),
    .b_i(b_q),
    .id_i(id_q),
    .xout_o(res_data_o),
    .gt_o(res_gt_o),
    .xid_o(res_id_o)
  );
  assign res_valid_o = state_q == RESP;
endmodule
